// File: rtl/scan_chain_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl_if
// Brief    : Host/chip signal bundle for the serial scan-chain master.
// Revision : 1.0 - initial release
// ============================================================================
interface scan_chain_ctrl_if #(
    parameter int N = 100
);
    logic         SC_clk_enb;
    logic         SC_data_enb;
    logic [N-1:0] data_in;
    logic         data_out;
    logic         SC_data;
    logic         SC_clk_chip;
    logic [N-1:0] SC_out;
    logic         SC_done;

    // Controller side
    modport master (
        input  SC_clk_enb, SC_data_enb, data_in, data_out,
        output SC_data, SC_clk_chip, SC_out, SC_done
    );

    // Host / chip side
    modport slave (
        output SC_clk_enb, SC_data_enb, data_in, data_out,
        input  SC_data, SC_clk_chip, SC_out, SC_done
    );
endinterface
`default_nettype wire

// File: rtl/scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scan_chain_ctrl
// Brief    : Serial scan-chain master; shifts data_in out MSB-first on a slow
//            scan clock while capturing the chip's scan output into SC_out.
//            Optional SCAN_LOOPBACK_EN: capture the outgoing SC_data instead.
// Revision : 1.0 - initial release
// ============================================================================
module scan_chain_ctrl #(
    parameter int N        = 100,
    parameter int HALF_PER = 50
) (
    input  wire logic            clki,
    input  wire logic            reset,
    scan_chain_ctrl_if.master    bus
);
    localparam int c_BIT_W  = $clog2(N + 1);
    localparam int c_HALF_W = $clog2(HALF_PER);
    localparam logic [c_BIT_W-1:0]  c_LAST_BIT  = c_BIT_W'(N - 1);
    localparam logic [c_HALF_W-1:0] c_HALF_LAST = c_HALF_W'(HALF_PER - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               r_state, w_state;
    logic [c_HALF_W-1:0]  r_half, w_half;
    logic [c_BIT_W-1:0]   r_bit_cnt, w_bit_cnt;
    logic [N-1:0]         r_tx, w_tx;
    logic [N-1:0]         r_rx, w_rx;
    logic [N-1:0]         r_sc_out, w_sc_out;
    logic                 r_sc_data, w_sc_data;
    logic                 r_sc_clk, w_sc_clk;
    logic                 r_sc_done, w_sc_done;

    logic r_enb_s1, r_enb_s2;
    logic r_req_s1, r_req_s2, r_req_d;
    logic w_start;
    logic w_sample;

    // Host-domain controls cross via two-flop synchronisers
    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            r_enb_s1 <= 1'b0;
            r_enb_s2 <= 1'b0;
            r_req_s1 <= 1'b0;
            r_req_s2 <= 1'b0;
            r_req_d  <= 1'b0;
        end else begin
            r_enb_s1 <= bus.SC_clk_enb;
            r_enb_s2 <= r_enb_s1;
            r_req_s1 <= bus.SC_data_enb;
            r_req_s2 <= r_req_s1;
            r_req_d  <= r_req_s2;
        end
    end

    assign w_start = r_req_s2 & ~r_req_d & r_enb_s2;

`ifdef SCAN_LOOPBACK_EN
    // Loopback captures the bit currently being driven to the chip
    assign w_sample = r_sc_data;
`else
    logic r_dout_s1, r_dout_s2;

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            r_dout_s1 <= 1'b0;
            r_dout_s2 <= 1'b0;
        end else begin
            r_dout_s1 <= bus.data_out;
            r_dout_s2 <= r_dout_s1;
        end
    end

    assign w_sample = r_dout_s2;
`endif

    always_ff @(posedge clki or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_half    <= '0;
            r_bit_cnt <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_sc_out  <= '0;
            r_sc_data <= 1'b0;
            r_sc_clk  <= 1'b0;
            r_sc_done <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_half    <= w_half;
            r_bit_cnt <= w_bit_cnt;
            r_tx      <= w_tx;
            r_rx      <= w_rx;
            r_sc_out  <= w_sc_out;
            r_sc_data <= w_sc_data;
            r_sc_clk  <= w_sc_clk;
            r_sc_done <= w_sc_done;
        end
    end

    always_comb begin
        w_state   = r_state;
        w_half    = r_half;
        w_bit_cnt = r_bit_cnt;
        w_tx      = r_tx;
        w_rx      = r_rx;
        w_sc_out  = r_sc_out;
        w_sc_data = r_sc_data;
        w_sc_clk  = r_sc_clk;
        w_sc_done = r_sc_done;

        case (r_state)
            S_IDLE: begin
                w_sc_clk  = 1'b0;
                w_sc_data = 1'b0;
                w_half    = '0;
                if (w_start) begin
                    w_tx      = bus.data_in;
                    w_rx      = '0;
                    w_bit_cnt = '0;
                    w_sc_done = 1'b0;
                    w_sc_data = bus.data_in[N-1];
                    w_state   = S_LOW;
                end
            end
            S_LOW: begin
                if (!r_enb_s2) begin
                    w_state   = S_IDLE;
                    w_sc_clk  = 1'b0;
                    w_sc_data = 1'b0;
                    w_half    = '0;
                end else if (r_half == c_HALF_LAST) begin
                    w_half   = '0;
                    w_sc_clk = 1'b1;
                    w_rx     = {r_rx[N-2:0], w_sample};
                    w_state  = S_HIGH;
                end else begin
                    w_half = r_half + c_HALF_W'(1);
                end
            end
            S_HIGH: begin
                if (!r_enb_s2) begin
                    w_state   = S_IDLE;
                    w_sc_clk  = 1'b0;
                    w_sc_data = 1'b0;
                    w_half    = '0;
                end else if (r_half == c_HALF_LAST) begin
                    w_half    = '0;
                    w_sc_clk  = 1'b0;
                    w_bit_cnt = r_bit_cnt + c_BIT_W'(1);
                    if (r_bit_cnt == c_LAST_BIT) begin
                        w_sc_out  = r_rx;
                        w_sc_done = 1'b1;
                        w_sc_data = 1'b0;
                        w_state   = S_DONE;
                    end else begin
                        // Rotate rather than shift so every tx bit stays live
                        w_tx      = {r_tx[N-2:0], r_tx[N-1]};
                        w_sc_data = r_tx[N-2];
                        w_state   = S_LOW;
                    end
                end else begin
                    w_half = r_half + c_HALF_W'(1);
                end
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.SC_data     = r_sc_data;
    assign bus.SC_clk_chip = r_sc_clk;
    assign bus.SC_out      = r_sc_out;
    assign bus.SC_done     = r_sc_done;

endmodule
`default_nettype wire

// File: tb/tb_scan_chain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_chain_ctrl
// Brief    : Directed self-checking bench for scan_chain_ctrl (N=8, HALF_PER=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_chain_ctrl;
    localparam int N        = 8;
    localparam int HALF_PER = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    scan_chain_ctrl_if #(.N(N)) bus ();

    scan_chain_ctrl #(.N(N), .HALF_PER(HALF_PER)) dut (
        .clki  (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] din;
        logic [7:0] chip;
        logic [7:0] exp_sent;
        logic [7:0] exp_out;
    } vec_t;

    vec_t vecs [4];
    int checks = 0;
    int errors = 0;

    // Edge monitors: each counter/array has a single writer
    int cyc = 0;
    int rise_cnt = 0, fall_cnt = 0, done_rises = 0;
    int rise_t [256];
    int fall_t [256];
    logic [7:0] sent = 8'h00;

    always @(posedge clk) cyc = cyc + 1;
    always @(posedge bus.SC_clk_chip) begin
        rise_t[rise_cnt & 255] = cyc;
        sent = {sent[6:0], bus.SC_data};
        rise_cnt = rise_cnt + 1;
    end
    always @(negedge bus.SC_clk_chip) begin
        fall_t[fall_cnt & 255] = cyc;
        fall_cnt = fall_cnt + 1;
    end
    always @(posedge bus.SC_done) done_rises = done_rises + 1;

    // Chip model: presents word MSB-first, advancing after each scan-clock fall
    logic [7:0] chip_word = 8'h00;
    int fall_base = 0;
    int chip_idx;
    logic chip_bit;
    always_comb begin
        chip_idx = fall_cnt - fall_base;
        chip_bit = 1'b0;
        if (chip_idx >= 0 && chip_idx < 8) chip_bit = chip_word[3'(7 - chip_idx)];
    end
    assign bus.data_out = chip_bit;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] capture_exp(input vec_t v);
`ifdef SCAN_LOOPBACK_EN
        return v.exp_sent;
`else
        return v.exp_out;
`endif
    endfunction

    task automatic run_xfer(input vec_t v, input string tag);
        int rb, db, c0, k;
        bit phase_ok;
        bus.SC_data_enb = 1'b0;
        chip_word = v.chip;
        fall_base = fall_cnt;
        bus.data_in = v.din;
        repeat (4) @(negedge clk);
        rb = rise_cnt;
        db = done_rises;
        c0 = cyc;
        bus.SC_data_enb = 1'b1;
        for (k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 3) check({tag, " done_drop"}, {31'd0, bus.SC_done}, 32'd0);
            if (k == 10) bus.data_in = ~v.din;
            if (k > 3 && bus.SC_done) break;
        end
        check({tag, " done_latency"}, k, 32'd67);
        check({tag, " first_rise"}, rise_t[rb & 255] - c0, 32'd7);
        repeat (3) @(negedge clk);
        check({tag, " rises"}, rise_cnt - rb, 32'd8);
        check({tag, " sent"}, {24'd0, sent}, {24'd0, v.exp_sent});
        check({tag, " sc_out"}, {24'd0, bus.SC_out}, {24'd0, capture_exp(v)});
        check({tag, " done"}, {31'd0, bus.SC_done}, 32'd1);
        check({tag, " done_rises"}, done_rises - db, 32'd1);
        check({tag, " idle_pins"}, {30'd0, bus.SC_clk_chip, bus.SC_data}, 32'd0);
        phase_ok = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (fall_t[(fall_base + j) & 255] - rise_t[(rb + j) & 255] != HALF_PER) phase_ok = 1'b0;
            if (j > 0 && rise_t[(rb + j) & 255] - rise_t[(rb + j - 1) & 255] != 2 * HALF_PER)
                phase_ok = 1'b0;
        end
        check({tag, " phase_timing"}, {31'd0, phase_ok}, 32'd1);
    endtask

    initial begin
        int rb, k;
        vec_t v;
        vecs[0] = '{din: 8'hA5, chip: 8'h3C, exp_sent: 8'hA5, exp_out: 8'h3C};
        vecs[1] = '{din: 8'h00, chip: 8'hFF, exp_sent: 8'h00, exp_out: 8'hFF};
        vecs[2] = '{din: 8'hFF, chip: 8'h81, exp_sent: 8'hFF, exp_out: 8'h81};
        vecs[3] = '{din: 8'h5A, chip: 8'h3C, exp_sent: 8'h5A, exp_out: 8'h3C};

        reset = 1'b1;
        bus.SC_clk_enb  = 1'b0;
        bus.SC_data_enb = 1'b0;
        bus.data_in     = 8'h00;
        repeat (3) @(negedge clk);
        check("reset clk_chip", {31'd0, bus.SC_clk_chip}, 32'd0);
        check("reset data", {31'd0, bus.SC_data}, 32'd0);
        check("reset done", {31'd0, bus.SC_done}, 32'd0);
        check("reset out", {24'd0, bus.SC_out}, 32'd0);
        reset = 1'b0;
        bus.SC_clk_enb = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 4; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

        // Abort after the third scan-clock rise
        v = '{din: 8'hFF, chip: 8'h00, exp_sent: 8'hFF, exp_out: 8'h00};
        bus.SC_data_enb = 1'b0;
        bus.data_in = v.din;
        repeat (4) @(negedge clk);
        rb = rise_cnt;
        bus.SC_data_enb = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rise_cnt - rb >= 3) break;
        end
        check("abort reach3", {31'd0, k < 200}, 32'd1);
        bus.SC_clk_enb = 1'b0;
        repeat (20) @(negedge clk);
        check("abort rises", rise_cnt - rb, 32'd3);
        check("abort clk_chip", {31'd0, bus.SC_clk_chip}, 32'd0);
        check("abort data", {31'd0, bus.SC_data}, 32'd0);
        check("abort done", {31'd0, bus.SC_done}, 32'd0);
        check("abort out", {24'd0, bus.SC_out}, 32'h3C);
        bus.SC_clk_enb = 1'b1;
        repeat (20) @(negedge clk);
        check("reenable no_run", rise_cnt - rb, 32'd3);

        // Re-trigger: held start does nothing, a fresh edge runs again
        run_xfer('{din: 8'h69, chip: 8'h96, exp_sent: 8'h69, exp_out: 8'h96}, "rt1");
        rb = rise_cnt;
        repeat (100) @(negedge clk);
        check("held_enb no_run", rise_cnt - rb, 32'd0);
        check("held_enb done", {31'd0, bus.SC_done}, 32'd1);
        run_xfer('{din: 8'h0F, chip: 8'hF0, exp_sent: 8'h0F, exp_out: 8'hF0}, "rt2");

        // Asynchronous reset in the middle of a run
        bus.SC_data_enb = 1'b0;
        repeat (4) @(negedge clk);
        rb = rise_cnt;
        bus.SC_data_enb = 1'b1;
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (rise_cnt - rb >= 2) break;
        end
        check("midrst reach2", {31'd0, k < 200}, 32'd1);
        repeat (1) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst clk_chip", {31'd0, bus.SC_clk_chip}, 32'd0);
        check("midrst data", {31'd0, bus.SC_data}, 32'd0);
        check("midrst done", {31'd0, bus.SC_done}, 32'd0);
        check("midrst out", {24'd0, bus.SC_out}, 32'd0);
        bus.SC_data_enb = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rb = rise_cnt;
        repeat (30) @(negedge clk);
        check("post_rst idle", rise_cnt - rb, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
